bft_packet_sender: RTL and testbench

- Transmit-side counterpart of the leaf interface's credit-checked receive path.
- Accepts a wide user-side valid/ready stream and serializes each beat into 32-bit payload words.
- Wraps each word into a 49-bit BFT packet with destination, port and sequence address.
- Emits packets only while credits for the remote leaf's receive BRAM are available; credits are returned by freespace-update packets arriving from the BFT.

---
 rtl/bft_packet_sender_pkg.sv | 36 +++
 rtl/bft_packet_sender_if.sv | 23 ++
 rtl/bft_credit_counter.sv | 53 +++++
 rtl/bft_packet_sender.sv | 101 ++++++++++
 tb/tb_bft_packet_sender.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bft_packet_sender_pkg.sv
// Shared definitions for the BFT packet sender: packet layout, the control port
// used for credit returns, the FSM state type and packet helpers.
package bft_packet_sender_pkg;

   // The BFT packet layout is fixed by the network, so the widths live here, not on the top.
   localparam int unsigned PACKET_BITS   = 49;
   localparam int unsigned PAYLOAD_BITS  = 32;
   localparam int unsigned NUM_LEAF_BITS = 5;
   localparam int unsigned NUM_PORT_BITS = 4;
   localparam int unsigned NUM_ADDR_BITS = 7;

   localparam int unsigned VALID_BIT = 48;
   localparam int unsigned LEAF_LSB  = 43;
   localparam int unsigned PORT_LSB  = 39;
   localparam int unsigned ADDR_LSB  = 32;

   localparam logic [NUM_PORT_BITS-1:0] CTRL_PORT_FREESPACE = 4'd1;

   typedef enum logic {StIdle, StSend} state_e;

   // Assemble a valid packet, MSB to LSB: valid, leaf, port, addr, payload.
   function automatic logic [PACKET_BITS-1:0] pack_packet(
      input logic [NUM_LEAF_BITS-1:0] leaf,
      input logic [NUM_PORT_BITS-1:0] port,
      input logic [NUM_ADDR_BITS-1:0] addr,
      input logic [PAYLOAD_BITS-1:0]  payload
   );
      return {1'b1, leaf, port, addr, payload};
   endfunction

   // A freespace update is any valid packet addressed to the freespace control port.
   function automatic logic is_credit_packet(input logic [PACKET_BITS-1:0] pkt);
      return pkt[VALID_BIT] && (pkt[PORT_LSB +: NUM_PORT_BITS] == CTRL_PORT_FREESPACE);
   endfunction

endpackage

// File: rtl/bft_packet_sender_if.sv
// User stream and BFT packet signals of the packet sender.
interface bft_packet_sender_if
   import bft_packet_sender_pkg::*;
#(
   parameter int unsigned IN_WIDTH = 128,
   parameter int unsigned PKT_BITS = PACKET_BITS
);
   logic [IN_WIDTH-1:0] din;
   logic                vld_in;
   logic                rdy_upward;
   logic [PKT_BITS-1:0] dout_leaf_interface2bft;
   logic [PKT_BITS-1:0] din_leaf_bft2interface;

   modport master (
      output din, vld_in, din_leaf_bft2interface,
      input  rdy_upward, dout_leaf_interface2bft
   );

   modport slave (
      input  din, vld_in, din_leaf_bft2interface,
      output rdy_upward, dout_leaf_interface2bft
   );
endinterface

// File: rtl/bft_credit_counter.sv
// Credits for the remote receive buffer: one consumed per emitted packet, a block
// returned per freespace update, clamped at the buffer depth with a sticky error.
module bft_credit_counter #(
   parameter int unsigned NUM_BRAM_ADDR_BITS    = 7,
   parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        consume,
   input  logic                        refill,
   output logic [NUM_BRAM_ADDR_BITS:0] credits,
   output logic                        credit_err
);
   localparam int unsigned CW = NUM_BRAM_ADDR_BITS + 1;
   // One spare bit so the sum can exceed the maximum before clamping.
   localparam logic [CW:0] MaxCredits = {2'b01, {NUM_BRAM_ADDR_BITS{1'b0}}};
   localparam logic [CW:0] RefillAmt  = (CW+1)'(FREESPACE_UPDATE_SIZE);

   logic [CW-1:0] credits_q, credits_d;
   logic          err_q, err_d;
   logic [CW:0]   sum;

   // Next credit count: add refill, subtract consumption, clamp on overflow.
   always_comb begin
      sum = {1'b0, credits_q};
      if (refill) begin
         sum = sum + RefillAmt;
      end
      if (consume) begin
         sum = sum - (CW+1)'(1);
      end
      credits_d = sum[CW-1:0];
      err_d     = err_q;
      if (sum > MaxCredits) begin
         credits_d = MaxCredits[CW-1:0];
         err_d     = 1'b1;
      end
   end

   // Credit and error registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         credits_q <= MaxCredits[CW-1:0];
         err_q     <= 1'b0;
      end else begin
         credits_q <= credits_d;
         err_q     <= err_d;
      end
   end

   assign credits    = credits_q;
   assign credit_err = err_q;
endmodule

// File: rtl/bft_packet_sender.sv
// Serializes wide user beats into 32-bit BFT packets, gated by remote-buffer credits.
module bft_packet_sender
   import bft_packet_sender_pkg::*;
#(
   parameter int unsigned IN_WIDTH              = 128,
   parameter int unsigned NUM_BRAM_ADDR_BITS    = 7,
   parameter int unsigned FREESPACE_UPDATE_SIZE = 64,
   parameter int unsigned DEST_LEAF             = 1,
   parameter int unsigned DEST_PORT             = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ap_start,
   bft_packet_sender_if.slave  bus,
   output logic                credit_err
);
   localparam int unsigned NumWords = IN_WIDTH / PAYLOAD_BITS;
   localparam int unsigned IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
   localparam logic [IdxW-1:0]          LastIdx = IdxW'(NumWords - 1);
   localparam logic [NUM_LEAF_BITS-1:0] Leaf    = NUM_LEAF_BITS'(DEST_LEAF);
   localparam logic [NUM_PORT_BITS-1:0] Port    = NUM_PORT_BITS'(DEST_PORT);

   state_e                    state_q;
   logic                      started_q;
   logic [IN_WIDTH-1:0]       shift_q;
   logic [IdxW-1:0]           idx_q;
   logic [NUM_ADDR_BITS-1:0]  addr_q;
   logic [PACKET_BITS-1:0]    dout_q;

   logic [NUM_BRAM_ADDR_BITS:0] credits;
   logic emit, last_word, rdy, accept, refill;

   assign emit      = (state_q == StSend) && (credits != '0);
   assign last_word = (idx_q == LastIdx);
   assign accept    = bus.vld_in && rdy;
   assign refill    = is_credit_packet(bus.din_leaf_bft2interface);

   // Ready when idle, or while the last word of a beat leaves so beats run back to back.
   always_comb begin
      rdy = started_q && ((state_q == StIdle) || (emit && last_word));
   end

   assign bus.rdy_upward              = rdy;
   assign bus.dout_leaf_interface2bft = dout_q;

   bft_credit_counter #(
      .NUM_BRAM_ADDR_BITS   (NUM_BRAM_ADDR_BITS),
      .FREESPACE_UPDATE_SIZE(FREESPACE_UPDATE_SIZE)
   ) u_credits (
      .clk       (clk),
      .reset     (reset),
      .consume   (emit),
      .refill    (refill),
      .credits   (credits),
      .credit_err(credit_err)
   );

   // Sender FSM: load a beat, then emit one packet per credited cycle, low word first.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         started_q <= 1'b0;
         shift_q   <= '0;
         idx_q     <= '0;
         addr_q    <= '0;
         dout_q    <= '0;
      end else begin
         if (ap_start) begin
            started_q <= 1'b1;
         end
         dout_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  shift_q <= bus.din;
                  idx_q   <= '0;
                  state_q <= StSend;
               end
            end
            StSend: begin
               if (emit) begin
                  dout_q <= pack_packet(Leaf, Port, addr_q, shift_q[PAYLOAD_BITS-1:0]);
                  addr_q <= addr_q + NUM_ADDR_BITS'(1);
                  if (last_word) begin
                     if (accept) begin
                        shift_q <= bus.din;
                        idx_q   <= '0;
                     end else begin
                        state_q <= StIdle;
                     end
                  end else begin
                     shift_q <= shift_q >> PAYLOAD_BITS;
                     idx_q   <= idx_q + IdxW'(1);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_bft_packet_sender.sv
// Self-checking bench for bft_packet_sender: a vector table for the basic beat,
// directed sequences for start, credits, wrap and reset, then random traffic
// checked against a word-queue reference model.
module tb_bft_packet_sender;
   logic clk = 1'b0;
   logic reset, ap_start, credit_err;

   always #5 clk = ~clk;

   bft_packet_sender_if #(.IN_WIDTH(128), .PKT_BITS(49)) bus ();

   bft_packet_sender dut (
      .clk       (clk),
      .reset     (reset),
      .ap_start  (ap_start),
      .bus       (bus),
      .credit_err(credit_err)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: pending words of the current beat, credit and address counters.
   int unsigned m_q[$];
   int          m_credits, m_addr;
   bit          m_started, m_err;
   logic [48:0] m_dout;

   int pkt_count, last_addr, wraps;

   localparam logic [48:0] CreditPkt = {1'b1, 5'd0, 4'd1, 39'd0};

   function automatic logic [48:0] pk(input int a, input logic [31:0] p);
      return {1'b1, 5'd1, 4'd2, 7'(a), p};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_credits = 128;
      m_addr    = 0;
      m_started = 0;
      m_err     = 0;
      m_dout    = '0;
   endtask

   function automatic bit model_rdy();
      return m_started && (m_q.size() == 0 || (m_q.size() == 1 && m_credits > 0));
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      bit acc, emit;
      int c;
      if (reset) begin
         model_reset();
         return;
      end
      acc    = model_rdy() && bus.vld_in;
      emit   = (m_q.size() > 0) && (m_credits > 0);
      c      = m_credits;
      m_dout = '0;
      if (emit) begin
         m_dout = pk(m_addr, m_q.pop_front());
         m_addr = (m_addr + 1) % 128;
         c      = c - 1;
      end
      if (bus.din_leaf_bft2interface[48] && bus.din_leaf_bft2interface[42:39] == 4'd1) c = c + 64;
      if (c > 128) begin
         c     = 128;
         m_err = 1;
      end
      m_credits = c;
      if (acc) begin
         for (int i = 0; i < 4; i++) m_q.push_back(bus.din[32*i +: 32]);
      end
      if (ap_start) m_started = 1;
   endtask

   // One cycle, entered just after a negedge with inputs driven.
   task automatic step(input bit has_exp, input logic exp_rdy, input logic [48:0] exp_dout);
      #1;
      chk("rdy_upward", bus.rdy_upward, model_rdy());
      if (has_exp) chk("tbl_rdy", bus.rdy_upward, exp_rdy);
      @(posedge clk);
      model_edge();
      #1;
      chk("dout", bus.dout_leaf_interface2bft, m_dout);
      chk("credit_err", credit_err, m_err);
      if (has_exp) chk("tbl_dout", bus.dout_leaf_interface2bft, exp_dout);
      if (reset) last_addr = -1;
      if (bus.dout_leaf_interface2bft[48]) begin
         pkt_count++;
         if (last_addr == 127) begin
            chk("addr_wrap", bus.dout_leaf_interface2bft[38:32], 0);
            wraps++;
         end
         last_addr = int'(bus.dout_leaf_interface2bft[38:32]);
      end
      @(negedge clk);
   endtask

   task automatic tick();
      step(1'b0, 1'b0, '0);
   endtask

   task automatic idle_inputs();
      reset                      = 1'b0;
      ap_start                   = 1'b0;
      bus.vld_in                 = 1'b0;
      bus.din                    = '0;
      bus.din_leaf_bft2interface = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   typedef struct {
      logic         ap_start;
      logic         vld;
      logic [127:0] din;
      logic         exp_rdy;
      logic [48:0]  exp_dout;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [127:0] d;
      bit found;
      d = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
      model_reset();
      pkt_count = 0;
      last_addr = -1;
      wraps     = 0;
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);

      // Reset state.
      tick();
      chk("reset_dout", bus.dout_leaf_interface2bft, 0);
      chk("reset_rdy", bus.rdy_upward, 0);
      chk("reset_credits", dut.u_credits.credits_q, 128);
      reset = 1'b0;

      // Basic beat from the vector table.
      tbl[0] = '{1'b1, 1'b0, '0, 1'b0, '0};
      tbl[1] = '{1'b0, 1'b1, d,  1'b1, '0};
      tbl[2] = '{1'b0, 1'b0, '0, 1'b0, pk(0, 32'h1111_1111)};
      tbl[3] = '{1'b0, 1'b0, '0, 1'b0, pk(1, 32'h2222_2222)};
      tbl[4] = '{1'b0, 1'b0, '0, 1'b0, pk(2, 32'h3333_3333)};
      tbl[5] = '{1'b0, 1'b0, '0, 1'b1, pk(3, 32'h4444_4444)};
      tbl[6] = '{1'b0, 1'b0, '0, 1'b1, '0};
      foreach (tbl[i]) begin
         ap_start   = tbl[i].ap_start;
         bus.vld_in = tbl[i].vld;
         bus.din    = tbl[i].din;
         step(1'b1, tbl[i].exp_rdy, tbl[i].exp_dout);
      end

      // Valid before start: no ready, no packets until a start pulse has been seen.
      do_reset();
      bus.vld_in = 1'b1;
      bus.din    = rnd128();
      for (int i = 0; i < 3; i++) tick();
      #1 chk("t2_rdy_before_start", bus.rdy_upward, 0);
      chk("t2_no_packet", bus.dout_leaf_interface2bft, 0);
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      #1 chk("t2_rdy_after_start", bus.rdy_upward, 1);
      tick();
      bus.vld_in = 1'b0;
      tick();
      chk("t2_first_packet", bus.dout_leaf_interface2bft[48], 1);
      for (int i = 0; i < 4; i++) tick();

      // Credit exhaustion with continuous beats, then one refill.
      do_reset();
      ap_start = 1'b1;
      tick();
      ap_start   = 1'b0;
      bus.vld_in = 1'b1;
      pkt_count  = 0;
      for (int i = 0; i < 200; i++) begin
         bus.din = rnd128();
         tick();
      end
      chk("t3_packets", pkt_count, 128);
      chk("t3_idle", bus.dout_leaf_interface2bft, 0);
      #1 chk("t3_rdy_low", bus.rdy_upward, 0);
      bus.din_leaf_bft2interface = CreditPkt;
      tick();
      bus.din_leaf_bft2interface = '0;
      pkt_count = 0;
      tick();
      chk("t3_resume", bus.dout_leaf_interface2bft[48], 1);
      for (int i = 0; i < 100; i++) tick();
      chk("t3_refill_packets", pkt_count, 64);

      // Address wrap with refills.
      do_reset();
      ap_start = 1'b1;
      tick();
      ap_start   = 1'b0;
      bus.vld_in = 1'b1;
      wraps      = 0;
      pkt_count  = 0;
      for (int i = 0; i < 200; i++) begin
         bus.din                    = rnd128();
         bus.din_leaf_bft2interface = (m_credits < 4) ? CreditPkt : '0;
         tick();
      end
      bus.din_leaf_bft2interface = '0;
      chk("t4_wrap_seen", wraps > 0, 1);
      chk("t4_enough_packets", pkt_count >= 130, 1);

      // Refill arriving while the last credit is spent.
      do_reset();
      ap_start = 1'b1;
      tick();
      ap_start   = 1'b0;
      bus.vld_in = 1'b1;
      found      = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         bus.din = rnd128();
         if (m_credits == 1 && m_q.size() > 0) begin
            bus.din_leaf_bft2interface = CreditPkt;
            found = 1;
         end
         tick();
      end
      bus.din_leaf_bft2interface = '0;
      chk("t5_found", found, 1);
      chk("t5_credits", dut.u_credits.credits_q, 64);
      chk("t5_no_err", credit_err, 0);

      // Refill at full credits overflows; error is sticky until reset.
      do_reset();
      bus.din_leaf_bft2interface = CreditPkt;
      tick();
      bus.din_leaf_bft2interface = '0;
      chk("t5_clamp", dut.u_credits.credits_q, 128);
      chk("t5_err_set", credit_err, 1);
      for (int i = 0; i < 5; i++) tick();
      chk("t5_err_sticky", credit_err, 1);
      do_reset();
      chk("t5_err_cleared", credit_err, 0);

      // Reset while the second word of a beat is going out.
      do_reset();
      ap_start = 1'b1;
      tick();
      ap_start   = 1'b0;
      bus.vld_in = 1'b1;
      bus.din    = d;
      tick();
      bus.vld_in = 1'b0;
      tick();
      chk("t6_word0", bus.dout_leaf_interface2bft, pk(0, 32'h1111_1111));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_dout_idle", bus.dout_leaf_interface2bft, 0);
      chk("t6_credits", dut.u_credits.credits_q, 128);
      ap_start = 1'b1;
      tick();
      ap_start   = 1'b0;
      bus.vld_in = 1'b1;
      bus.din    = d;
      tick();
      bus.vld_in = 1'b0;
      tick();
      chk("t6_restart_packet", bus.dout_leaf_interface2bft, pk(0, 32'h1111_1111));

      // Random traffic against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int r;
         reset      = ($urandom_range(0, 499) == 0);
         ap_start   = ($urandom_range(0, 15) == 0);
         bus.vld_in = ($urandom_range(0, 2) != 0);
         bus.din    = rnd128();
         r          = $urandom_range(0, 29);
         if (r == 0) begin
            bus.din_leaf_bft2interface = CreditPkt;
         end else if (r == 1) begin
            bus.din_leaf_bft2interface = {1'b0, 5'($urandom()), 4'd1, 7'($urandom()), 32'($urandom())};
         end else if (r == 2) begin
            bus.din_leaf_bft2interface =
               {1'b1, 5'($urandom()), 4'($urandom_range(2, 15)), 7'($urandom()), 32'($urandom())};
         end else begin
            bus.din_leaf_bft2interface = '0;
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
